// File: rtl/bc_pkg.sv
// Shared encodings for the basic-computer hardwired control unit:
// opcodes, bus sources, ALU operations and register-reference bit positions.
package bc_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_RIO = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'd0,
    ALU_AND  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_PASS = 3'd3,
    ALU_CMA  = 3'd4
  } alu_op_e;

  localparam int IR_I_BIT = 15;
  localparam int RR_CLA   = 11;
  localparam int RR_CMA   = 9;
  localparam int RR_INC   = 5;
  localparam int RR_SPA   = 4;
  localparam int RR_SNA   = 3;
  localparam int RR_SZA   = 2;
  localparam int RR_HLT   = 0;

endpackage

// File: rtl/bc_seq_counter.sv
// Sequence counter SC with clear-over-increment and one-hot T0..T6 decode.
// Values above 6 decode to an all-zero one-hot vector.
module bc_seq_counter #(
  parameter int SC_W = 3
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [SC_W-1:0] sc_o,
  output logic [6:0]      t_o
);

  logic [SC_W-1:0] sc_q, sc_d;

  always_comb begin
    sc_d = sc_q;
    if (clr_i) begin
      sc_d = '0;
    end else if (inc_i) begin
      sc_d = sc_q + SC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign sc_o = sc_q;

  for (genvar k = 0; k < 7; k++) begin : g_tdec
    assign t_o[k] = (sc_q == SC_W'(k));
  end

endmodule

// File: rtl/bc_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 16-bit basic computer.
// Strobes are combinational from SC, I, IR and flags, forced low while RUN=0.
module bc_control_unit
  import bc_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int SC_W   = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [WORD_W-1:0] IR,
  input  logic              DR_ZERO,
  input  logic              AC_ZERO,
  input  logic              AC_SIGN,
  output logic              AR_LD,
  output logic              AR_INC,
  output logic              PC_LD,
  output logic              PC_INC,
  output logic              DR_LD,
  output logic              DR_INC,
  output logic              AC_LD,
  output logic              AC_CLR,
  output logic              AC_INC,
  output logic              IR_LD,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [2:0]        BUS_SEL,
  output logic [2:0]        ALU_OP,
  output logic              RUN,
  output logic [SC_W-1:0]   T_STATE
);

  logic       run_q, run_d;
  logic       i_q, i_d;
  logic [6:0] t;
  logic       end_cyc;
  logic       halt;
  opcode_e    d;
  logic       unused_ir;

  assign d         = opcode_e'(IR[14:12]);
  assign unused_ir = ^{IR[10], IR[8:6], IR[1]};

  bc_seq_counter #(.SC_W(SC_W)) u_sc (
    .CLK   (CLK),
    .CLR   (CLR),
    .inc_i (run_q & ~end_cyc),
    .clr_i (~run_q | end_cyc),
    .sc_o  (T_STATE),
    .t_o   (t)
  );

  always_comb begin
    AR_LD   = 1'b0;
    AR_INC  = 1'b0;
    PC_LD   = 1'b0;
    PC_INC  = 1'b0;
    DR_LD   = 1'b0;
    DR_INC  = 1'b0;
    AC_LD   = 1'b0;
    AC_CLR  = 1'b0;
    AC_INC  = 1'b0;
    IR_LD   = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    BUS_SEL = BUS_NONE;
    ALU_OP  = ALU_NOP;
    end_cyc = 1'b0;
    halt    = 1'b0;
    if (run_q) begin
      if (t[0]) begin
        BUS_SEL = BUS_PC;
        AR_LD   = 1'b1;
      end else if (t[1]) begin
        MEM_RD  = 1'b1;
        BUS_SEL = BUS_MEM;
        IR_LD   = 1'b1;
        PC_INC  = 1'b1;
      end else if (t[2]) begin
        BUS_SEL = BUS_IR;
        AR_LD   = 1'b1;
      end else if (t[3]) begin
        if (d == OP_RIO) begin
          end_cyc = 1'b1;
          if (!i_q) begin
            // AC strobes may coincide; the AC register resolves CLR > LD > INC
            AC_CLR = IR[RR_CLA];
            AC_INC = IR[RR_INC];
            if (IR[RR_CMA]) begin
              AC_LD  = 1'b1;
              ALU_OP = ALU_CMA;
            end
            PC_INC = (IR[RR_SPA] & ~AC_SIGN) | (IR[RR_SNA] & AC_SIGN) |
                     (IR[RR_SZA] & AC_ZERO);
            halt   = IR[RR_HLT];
          end
        end else if (i_q) begin
          MEM_RD  = 1'b1;
          BUS_SEL = BUS_MEM;
          AR_LD   = 1'b1;
        end
      end else if (t[4]) begin
        case (d)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            MEM_RD  = 1'b1;
            BUS_SEL = BUS_MEM;
            DR_LD   = 1'b1;
          end
          OP_STA: begin
            BUS_SEL = BUS_AC;
            MEM_WR  = 1'b1;
            end_cyc = 1'b1;
          end
          OP_BUN: begin
            BUS_SEL = BUS_AR;
            PC_LD   = 1'b1;
            end_cyc = 1'b1;
          end
          OP_BSA: begin
            BUS_SEL = BUS_PC;
            MEM_WR  = 1'b1;
            AR_INC  = 1'b1;
          end
          default: end_cyc = 1'b1;
        endcase
      end else if (t[5]) begin
        case (d)
          OP_AND: begin
            AC_LD   = 1'b1;
            ALU_OP  = ALU_AND;
            end_cyc = 1'b1;
          end
          OP_ADD: begin
            AC_LD   = 1'b1;
            ALU_OP  = ALU_ADD;
            end_cyc = 1'b1;
          end
          OP_LDA: begin
            AC_LD   = 1'b1;
            ALU_OP  = ALU_PASS;
            end_cyc = 1'b1;
          end
          OP_BSA: begin
            BUS_SEL = BUS_AR;
            PC_LD   = 1'b1;
            end_cyc = 1'b1;
          end
          OP_ISZ:  DR_INC  = 1'b1;
          default: end_cyc = 1'b1;
        endcase
      end else if (t[6]) begin
        end_cyc = 1'b1;
        if (d == OP_ISZ) begin
          // DR_ZERO already reflects the increment done in T5
          BUS_SEL = BUS_DR;
          MEM_WR  = 1'b1;
          PC_INC  = DR_ZERO;
        end
      end else begin
        end_cyc = 1'b1;
      end
    end
  end

  always_comb begin
    run_d = run_q ? ~halt : START;
    i_d   = (run_q & t[2]) ? IR[IR_I_BIT] : i_q;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      run_q <= 1'b0;
      i_q   <= 1'b0;
    end else begin
      run_q <= run_d;
      i_q   <= i_d;
    end
  end

  assign RUN = run_q;

endmodule

// File: tb/tb_bc_control_unit.sv
// Directed and random instruction streams against a per-instruction micro-op list model.
module tb_bc_control_unit;

  logic        CLK = 1'b0;
  logic        CLR, START;
  logic [15:0] IR;
  logic        DR_ZERO, AC_ZERO, AC_SIGN;
  logic        AR_LD, AR_INC, PC_LD, PC_INC, DR_LD, DR_INC;
  logic        AC_LD, AC_CLR, AC_INC, IR_LD, MEM_RD, MEM_WR;
  logic [2:0]  BUS_SEL, ALU_OP;
  logic        RUN;
  logic [2:0]  T_STATE;

  int nchk = 0;
  int nerr = 0;

  localparam logic [11:0] ARL = 12'h800, ARI = 12'h400, PCL = 12'h200, PCI = 12'h100;
  localparam logic [11:0] DRL = 12'h080, DRI = 12'h040, ACL = 12'h020, ACC = 12'h010;
  localparam logic [11:0] ACI = 12'h008, IRL = 12'h004, MRD = 12'h002, MWR = 12'h001;

  logic [17:0] exp_q[$];
  logic [17:0] obs;

  assign obs = {AR_LD, AR_INC, PC_LD, PC_INC, DR_LD, DR_INC, AC_LD, AC_CLR, AC_INC,
                IR_LD, MEM_RD, MEM_WR, BUS_SEL, ALU_OP};

  always #5 CLK = ~CLK;

  bc_control_unit #(.WORD_W(16), .SC_W(3)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .IR(IR),
    .DR_ZERO(DR_ZERO), .AC_ZERO(AC_ZERO), .AC_SIGN(AC_SIGN),
    .AR_LD(AR_LD), .AR_INC(AR_INC), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .DR_LD(DR_LD), .DR_INC(DR_INC), .AC_LD(AC_LD), .AC_CLR(AC_CLR), .AC_INC(AC_INC),
    .IR_LD(IR_LD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .BUS_SEL(BUS_SEL), .ALU_OP(ALU_OP), .RUN(RUN), .T_STATE(T_STATE)
  );

  function automatic logic [17:0] mo(input logic [11:0] s, input logic [2:0] bus,
                                     input logic [2:0] alu);
    return {s, bus, alu};
  endfunction

  // Expected cycle-by-cycle micro-operations of one whole instruction.
  function automatic void build(input logic [15:0] ir, input logic acs, input logic acz,
                                input logic drz, output bit halts);
    logic [2:0]  op;
    logic [11:0] s;
    logic [2:0]  alu;
    op    = ir[14:12];
    halts = 1'b0;
    exp_q.delete();
    exp_q.push_back(mo(ARL, 3'd2, 3'd0));
    exp_q.push_back(mo(MRD | IRL | PCI, 3'd7, 3'd0));
    exp_q.push_back(mo(ARL, 3'd5, 3'd0));
    if (op == 3'd7) begin
      s   = 12'h0;
      alu = 3'd0;
      if (!ir[15]) begin
        if (ir[11]) s = s | ACC;
        if (ir[9]) begin
          s   = s | ACL;
          alu = 3'd4;
        end
        if (ir[5]) s = s | ACI;
        if ((ir[4] && !acs) || (ir[3] && acs) || (ir[2] && acz)) s = s | PCI;
        halts = ir[0];
      end
      exp_q.push_back(mo(s, 3'd0, alu));
    end else begin
      exp_q.push_back(ir[15] ? mo(MRD | ARL, 3'd7, 3'd0) : mo(12'h0, 3'd0, 3'd0));
      case (op)
        3'd0, 3'd1, 3'd2: begin
          exp_q.push_back(mo(MRD | DRL, 3'd7, 3'd0));
          exp_q.push_back(mo(ACL, 3'd0, op + 3'd1));
        end
        3'd3: exp_q.push_back(mo(MWR, 3'd4, 3'd0));
        3'd4: exp_q.push_back(mo(PCL, 3'd1, 3'd0));
        3'd5: begin
          exp_q.push_back(mo(MWR | ARI, 3'd2, 3'd0));
          exp_q.push_back(mo(PCL, 3'd1, 3'd0));
        end
        default: begin
          exp_q.push_back(mo(MRD | DRL, 3'd7, 3'd0));
          exp_q.push_back(mo(DRI, 3'd0, 3'd0));
          exp_q.push_back(mo(MWR | (drz ? PCI : 12'h0), 3'd3, 3'd0));
        end
      endcase
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      check("idle.out", 32'(obs), 32'd0);
      check("idle.run", 32'(RUN), 32'd0);
      check("idle.T", 32'(T_STATE), 32'd0);
      @(negedge CLK);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic exec(input logic [15:0] ir, input logic acs, input logic acz,
                      input logic drz, input int abort_at, input bit start_on_last);
    bit halts;
    IR      = ir;
    AC_SIGN = acs;
    AC_ZERO = acz;
    DR_ZERO = drz;
    build(ir, acs, acz, drz, halts);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%h.T%0d.out", ir, i), 32'(obs), 32'(exp_q[i]));
      check($sformatf("%h.T%0d.T", ir, i), 32'(T_STATE), 32'(i));
      check($sformatf("%h.T%0d.run", ir, i), 32'(RUN), 32'd1);
      if (i == abort_at) begin
        CLR = 1'b1;
        #1;
        check("abort.out", 32'(obs), 32'd0);
        check("abort.run", 32'(RUN), 32'd0);
        check("abort.T", 32'(T_STATE), 32'd0);
        @(negedge CLK);
        CLR = 1'b0;
        idle(2);
        return;
      end
      if (i == exp_q.size() - 1 && start_on_last) START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    if (halts) idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rir;
    logic [2:0]  rop;
    logic [11:0] radr;
    CLR     = 1'b1;
    START   = 1'b0;
    IR      = 16'h0;
    DR_ZERO = 1'b0;
    AC_ZERO = 1'b0;
    AC_SIGN = 1'b0;
    #2;
    check("reset.out", 32'(obs), 32'd0);
    check("reset.run", 32'(RUN), 32'd0);
    check("reset.T", 32'(T_STATE), 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    idle(2);

    // ADD abandoned by reset during T4
    pulse_start();
    exec(16'h1050, 1'b0, 1'b0, 1'b0, 4, 1'b0);

    pulse_start();
    exec(16'h1050, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'hA0F0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h20F0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h6020, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    exec(16'h6020, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h5100, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h7804, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    exec(16'h7804, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h7220, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    exec(16'hF7FF, 1'b0, 1'b1, 1'b0, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop  = 3'($urandom_range(0, 7));
      radr = 12'($urandom);
      rir  = {1'($urandom), rop, radr};
      if (rop == 3'd7 && !rir[15]) rir[0] = 1'b0;
      exec(rir, 1'($urandom), 1'($urandom), 1'($urandom), -1, 1'b0);
    end

    // HLT with a coincident START: the START must be ignored
    exec(16'h7001, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    pulse_start();
    exec(16'h0123, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h3456, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    exec(16'h4FFF, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    check("restart.T0", 32'(T_STATE), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bc_control_unit.md
Name: bc_control_unit

Overview:
- Hardwired control sequencer for the 16-bit basic-computer datapath.
- Runs the fetch, decode and execute timing T0..T6 using an internal sequence counter.
- Drives the LD/INC/CLR strobes of AR, PC, DR, AC and IR, plus the common-bus select, ALU op and memory read/write.
- Executes all seven memory-reference instructions (direct and indirect) and the register-reference subset CLA, CMA, INC, SPA, SNA, SZA, HLT.

Parameters:
- WORD_W, 16, instruction/data word width. Fixed format: bit 15 = I, bits 14:12 = opcode, bits 11:0 = address.
- SC_W, 3, sequence-counter width. Must be ≥3 to count 0..6.

Ports:
- CLK  in  1  clock
- CLR  in  1  asynchronous active-high reset
- START  in  1  sets the RUN flip-flop when idle
- IR  in  WORD_W  current IR register contents
- DR_ZERO  in  1  DR output == 0
- AC_ZERO  in  1  AC output == 0
- AC_SIGN  in  1  AC[15]
- AR_LD, AR_INC  out  1 each
- PC_LD, PC_INC  out  1 each
- DR_LD, DR_INC  out  1 each
- AC_LD, AC_CLR, AC_INC  out  1 each
- IR_LD  out  1
- MEM_RD, MEM_WR  out  1 each
- BUS_SEL  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM
- ALU_OP  out  3  0 nop, 1 AND, 2 ADD, 3 pass DR, 4 complement AC
- RUN  out  1  S flip-flop
- T_STATE  out  SC_W  current SC value

Behaviour:
- Reset (CLR=1, asynchronous): SC=0, I=0, RUN=0. Every strobe is 0, BUS_SEL=0, ALU_OP=0, effective immediately.
- Reset mid-instruction abandons it; no partial strobes after CLR rises.
- Outputs are combinational from SC, the I flip-flop, IR and the flags, gated by RUN. RUN=0 forces all strobes to 0 and holds SC at 0.
- START is sampled at posedge only when RUN=0 and sets RUN. START while RUN=1 is ignored.
- Decode: D = IR[14:12].
- SC advances by 1 each cycle while RUN=1. The cycle marked "end" clears SC to 0, so the next cycle is T0.
- Fetch and decode:
  - T0: BUS_SEL=2, AR_LD.
  - T1: MEM_RD, BUS_SEL=7, IR_LD, PC_INC.
  - T2: BUS_SEL=5, AR_LD; I ← IR[15] at the clock edge.
- T3, D=7, I=0 (register-reference), end. All selected bits act in the same cycle:
  - IR[11] CLA: AC_CLR.
  - IR[9] CMA: ALU_OP=4, AC_LD.
  - IR[5] INC: AC_INC.
  - IR[4] SPA: PC_INC if AC_SIGN=0.
  - IR[3] SNA: PC_INC if AC_SIGN=1.
  - IR[2] SZA: PC_INC if AC_ZERO=1.
  - IR[0] HLT: RUN ← 0.
  - Simultaneous AC strobes are resolved by AC priority CLR > LD > INC. The control unit does not arbitrate them.
- T3, D=7, I=1 (I/O): no strobes, end.
- T3, D≠7: if I=1, MEM_RD, BUS_SEL=7, AR_LD (indirect address); if I=0, no strobes. Continue to T4.
- Execute:
  - AND, ADD, LDA (D=0, 1, 2): T4 MEM_RD, BUS_SEL=7, DR_LD. T5 AC_LD with ALU_OP = 1, 2 or 3 respectively, end.
  - STA (D=3): T4 BUS_SEL=4, MEM_WR, end.
  - BUN (D=4): T4 BUS_SEL=1, PC_LD, end.
  - BSA (D=5): T4 BUS_SEL=2, MEM_WR, AR_INC. T5 BUS_SEL=1, PC_LD, end.
  - ISZ (D=6): T4 MEM_RD, BUS_SEL=7, DR_LD. T5 DR_INC. T6 BUS_SEL=3, MEM_WR, PC_INC if DR_ZERO=1, end.
  - DR_ZERO at T6 reflects the incremented value; DR wraps FFFF→0000, so ISZ on FFFF skips.
- At most one of LD/INC is asserted per register per cycle, except the documented AC register-reference case.
- MEM_RD and MEM_WR are never asserted together.
- SC never exceeds 6. Unreachable SC values behave as end with no strobes.

Decomposition:
- bc_pkg holds shared constants:
  - opcode values AND..ISZ
  - BUS_SEL codes
  - ALU_OP codes
  - register-reference bit indices
- One sub-module, bc_seq_counter: SC_W-bit counter with INC/CLR (clear over increment), async CLR. It outputs SC and a one-hot T0..T6 decode.

Test Plan:
1. START, then CLR pulsed during T4 of ADD → RUN=0, T_STATE=0, all strobes 0 immediately; no activity until the next START.
2. IR=16'h1050 (ADD direct) → T0 BUS_SEL=2/AR_LD; T1 MEM_RD/IR_LD/PC_INC; T2 BUS_SEL=5/AR_LD; T3 idle; T4 DR_LD/BUS_SEL=7; T5 AC_LD/ALU_OP=2; 7th cycle T_STATE=0.
3. IR=16'hA0F0 (LDA indirect) → T3 MEM_RD/BUS_SEL=7/AR_LD; T5 ALU_OP=3/AC_LD; IR=16'h20F0 → T3 no strobes.
4. IR=16'h6020 (ISZ), DR_ZERO=1 at T6 → MEM_WR, BUS_SEL=3, PC_INC; repeat with DR_ZERO=0 → MEM_WR only, no PC_INC.
5. IR=16'h5100 (BSA) → T4 MEM_WR/BUS_SEL=2/AR_INC; T5 BUS_SEL=1/PC_LD; next cycle T0.
6. IR=16'h7804 with AC_ZERO=1 → AC_CLR and PC_INC in the same T3; IR=16'h7001 → RUN falls after T3, outputs stay 0; START simultaneous with HLT is ignored; a later START restarts at T0.
